second_chance_ctrl: RTL and testbench
=====================================

Name: second_chance_ctrl

Overview:
Request sequencer for the second-chance key cell array. Accepts lookup/insert/delete requests over a valid/ready handshake and drives the array's key, chip-select, one-hot write and one-hot delete vectors. Keeps one reference bit per entry plus a clock hand for second-chance replacement when the array is full. Sits between the hashtable front end and the key cell array; the value store is indexed by resp_index.

Parameters:
KEY_WIDTH, 32, key width in bits
MEM_SIZE, 128, number of key cells (>=2)
IDX_W, $clog2(MEM_SIZE), index width (derived, localparam)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_op  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved (treated as LOOKUP)
req_key  in  KEY_WIDTH  request key
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_hit  out  1  key was present before this operation
resp_index  out  IDX_W  entry used (hit/written/deleted)
resp_evicted  out  1  INSERT overwrote a victim entry
key_write_o  out  KEY_WIDTH  to array key_write_i
key_read_o  out  KEY_WIDTH  to array key_read_i
cs_o  out  1  to array cs
we_o  out  MEM_SIZE  one-hot write enable
del_o  out  MEM_SIZE  one-hot delete enable
empty_i  in  MEM_SIZE  from array
fits_read_i  in  MEM_SIZE  from array
fits_write_i  in  MEM_SIZE  from array

Behaviour:
- Reset (async, active-high): state IDLE; req_ready=1, resp_valid=0, resp_hit=0, resp_index=0, resp_evicted=0, cs_o=0, we_o=0, del_o=0, key_*_o=0, all ref bits=0, hand=0. Reset mid-operation aborts it; no partial write survives in controller state.
- FSM: IDLE -> PROBE -> (SWEEP)* -> ACT -> RESP -> IDLE.
- IDLE: req_ready=1; on req_valid&&req_ready latch op/key, go PROBE. req_ready=0 in all other states (one request in flight).
- PROBE (1 cycle): key_read_o=key_write_o=latched key, cs_o=1; register fits_read_i/fits_write_i/empty_i at end of cycle.
- ACT decision (from registered match vectors; one-hot assumed, lowest index wins if not):
  LOOKUP: hit -> set ref[idx], resp_hit=1, resp_index=idx; miss -> resp_hit=0, resp_index=0. No we/del.
  DELETE: hit -> del_o one-hot at idx for exactly 1 cycle, ref[idx]=0, resp_hit=1; miss -> no del, resp_hit=0.
  INSERT: hit -> ref[idx]=1, resp_hit=1, no write. Else any empty -> lowest empty index, we_o one-hot 1 cycle, ref=1. Else go SWEEP.
- SWEEP: one entry per cycle at hand: ref[hand]=1 -> clear, hand++ (wrap MEM_SIZE-1 -> 0); ref[hand]=0 -> victim=hand, hand++, go ACT with we_o one-hot at victim, ref[victim]=1, resp_evicted=1. Bounded: at most MEM_SIZE+1 SWEEP cycles.
- cs_o=1 in PROBE and ACT, else 0; we_o/del_o never both nonzero, never more than one bit set.
- RESP: resp_valid=1, outputs stable until resp_ready; then IDLE. Best-case latency accept->resp_valid = 3 cycles (PROBE, ACT, RESP).
- Hand advances only in SWEEP; empty-slot inserts and deletes do not move it.

Optional Feature:
SECOND_CHANCE_STATS_EN: defined -> adds 32-bit saturating counters stat_hits, stat_misses, stat_evictions (outputs, reset 0), stat_clr input (sync clear, priority over increment); counted at RESP handshake. Undefined -> ports and counters absent; behaviour otherwise identical.

Decomposition:
- second_chance_pkg: op_e enum (LOOKUP/INSERT/DELETE), state_e enum, OP_W=2 constant.
- Sub-module sc_prio_enc: MEM_SIZE-bit vector -> lowest-set index + any flag; instanced for match and empty vectors.

Test Plan:
- MEM_SIZE=4, INSERT keys 0xA,0xB,0xC,0xD -> we_o one-hot 0001,0010,0100,1000; resp_index 0..3, resp_hit=0, resp_evicted=0.
- LOOKUP 0xB after above -> resp_hit=1, resp_index=1, we_o/del_o stay 0, latency 3 cycles.
- Full array, all ref=1, INSERT 0xE -> 4 clears then victim index 0, resp_evicted=1, hand=1; LOOKUP 0xA -> miss.
- DELETE 0xC -> del_o=0100 for 1 cycle, resp_hit=1; INSERT 0xF -> written at index 2, no eviction.
- resp_ready held low 5 cycles -> resp_* stable, req_ready=0; request presented meanwhile not accepted.
- reset asserted during SWEEP -> all outputs to reset values same cycle, ref bits and hand = 0.

Source files
------------

// File: rtl/second_chance_pkg.sv
// Shared types for the second-chance request sequencer.
package second_chance_pkg;

  localparam int unsigned OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OpLookup = 2'd0,
    OpInsert = 2'd1,
    OpDelete = 2'd2
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StProbe,
    StSweep,
    StAct,
    StResp
  } state_e;

endpackage

// File: rtl/sc_prio_enc.sv
// Lowest-set-bit priority encoder with an any-bit-set flag.
module sc_prio_enc #(
  parameter int unsigned WIDTH = 128,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/second_chance_ctrl.sv
// Lookup/insert/delete sequencer for the key cell array with second-chance eviction.
// Optional saturating statistics counters: define SECOND_CHANCE_STATS_EN.
module second_chance_ctrl
  import second_chance_pkg::*;
#(
  parameter int unsigned KEY_WIDTH = 32,
  parameter int unsigned MEM_SIZE  = 128,
  localparam int unsigned IDX_W    = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [OP_W-1:0]      req_op,
  input  logic [KEY_WIDTH-1:0] req_key,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [IDX_W-1:0]     resp_index,
  output logic                 resp_evicted,
  output logic [KEY_WIDTH-1:0] key_write_o,
  output logic [KEY_WIDTH-1:0] key_read_o,
  output logic                 cs_o,
  output logic [MEM_SIZE-1:0]  we_o,
  output logic [MEM_SIZE-1:0]  del_o,
  input  logic [MEM_SIZE-1:0]  empty_i,
  input  logic [MEM_SIZE-1:0]  fits_read_i,
  input  logic [MEM_SIZE-1:0]  fits_write_i
`ifdef SECOND_CHANCE_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_misses,
  output logic [31:0]          stat_evictions
`endif
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [MEM_SIZE-1:0]  rd_match_q, wr_match_q, empty_q;
  logic [MEM_SIZE-1:0]  ref_q, ref_d;
  logic [IDX_W-1:0]     hand_q, hand_d, victim_q, victim_d;
  logic                 evict_q, evict_d;
  logic                 resp_hit_q, resp_hit_d, resp_evicted_q, resp_evicted_d;
  logic [IDX_W-1:0]     resp_index_q, resp_index_d;

  logic [MEM_SIZE-1:0]  act_match;
  logic [IDX_W-1:0]     m_idx, e_idx;
  logic                 m_any, e_any;

  // Inserts match on the write port, lookups and deletes on the read port.
  assign act_match = (op_q == OpInsert) ? wr_match_q : rd_match_q;

  sc_prio_enc #(.WIDTH(MEM_SIZE)) u_match_enc (.vec(act_match), .idx(m_idx), .any(m_any));
  sc_prio_enc #(.WIDTH(MEM_SIZE)) u_empty_enc (.vec(empty_q),   .idx(e_idx), .any(e_any));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      op_q           <= OpLookup;
      key_q          <= '0;
      rd_match_q     <= '0;
      wr_match_q     <= '0;
      empty_q        <= '0;
      ref_q          <= '0;
      hand_q         <= '0;
      victim_q       <= '0;
      evict_q        <= 1'b0;
      resp_hit_q     <= 1'b0;
      resp_index_q   <= '0;
      resp_evicted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      key_q          <= key_d;
      ref_q          <= ref_d;
      hand_q         <= hand_d;
      victim_q       <= victim_d;
      evict_q        <= evict_d;
      resp_hit_q     <= resp_hit_d;
      resp_index_q   <= resp_index_d;
      resp_evicted_q <= resp_evicted_d;
      if (state_q == StProbe) begin
        rd_match_q <= fits_read_i;
        wr_match_q <= fits_write_i;
        empty_q    <= empty_i;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    key_d          = key_q;
    ref_d          = ref_q;
    hand_d         = hand_q;
    victim_d       = victim_q;
    evict_d        = evict_q;
    resp_hit_d     = resp_hit_q;
    resp_index_d   = resp_index_q;
    resp_evicted_d = resp_evicted_q;
    req_ready      = 1'b0;
    cs_o           = 1'b0;
    key_read_o     = '0;
    key_write_o    = '0;
    we_o           = '0;
    del_o          = '0;

    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          unique case (req_op)
            2'd1:    op_d = OpInsert;
            2'd2:    op_d = OpDelete;
            default: op_d = OpLookup;
          endcase
          key_d   = req_key;
          evict_d = 1'b0;
          state_d = StProbe;
        end
      end
      StProbe: begin
        cs_o        = 1'b1;
        key_read_o  = key_q;
        key_write_o = key_q;
        state_d     = StAct;
      end
      StAct: begin
        cs_o           = 1'b1;
        key_read_o     = key_q;
        key_write_o    = key_q;
        state_d        = StResp;
        resp_evicted_d = 1'b0;
        resp_hit_d     = m_any;
        resp_index_d   = m_any ? m_idx : '0;
        if (evict_q) begin
          we_o[victim_q]  = 1'b1;
          ref_d[victim_q] = 1'b1;
          resp_hit_d      = 1'b0;
          resp_index_d    = victim_q;
          resp_evicted_d  = 1'b1;
        end else begin
          unique case (op_q)
            OpLookup: if (m_any) ref_d[m_idx] = 1'b1;
            OpDelete: begin
              if (m_any) begin
                del_o[m_idx] = 1'b1;
                ref_d[m_idx] = 1'b0;
              end
            end
            OpInsert: begin
              if (m_any) begin
                ref_d[m_idx] = 1'b1;
              end else if (e_any) begin
                we_o[e_idx]  = 1'b1;
                ref_d[e_idx] = 1'b1;
                resp_index_d = e_idx;
              end else begin
                state_d = StSweep;
              end
            end
            default: ;
          endcase
        end
      end
      StSweep: begin
        hand_d = (hand_q == IDX_W'(MEM_SIZE - 1)) ? '0 : hand_q + 1'b1;
        if (ref_q[hand_q]) begin
          ref_d[hand_q] = 1'b0;
        end else begin
          victim_d = hand_q;
          evict_d  = 1'b1;
          state_d  = StAct;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign resp_valid   = (state_q == StResp);
  assign resp_hit     = resp_hit_q;
  assign resp_index   = resp_index_q;
  assign resp_evicted = resp_evicted_q;

`ifdef SECOND_CHANCE_STATS_EN
  logic [31:0] hits_q, misses_q, evictions_q;
  logic        resp_fire;

  assign resp_fire = resp_valid && resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hits_q      <= '0;
      misses_q    <= '0;
      evictions_q <= '0;
    end else if (stat_clr) begin
      hits_q      <= '0;
      misses_q    <= '0;
      evictions_q <= '0;
    end else if (resp_fire) begin
      if (resp_hit_q && (hits_q != '1))          hits_q      <= hits_q + 32'd1;
      if (!resp_hit_q && (misses_q != '1))       misses_q    <= misses_q + 32'd1;
      if (resp_evicted_q && (evictions_q != '1)) evictions_q <= evictions_q + 32'd1;
    end
  end

  assign stat_hits      = hits_q;
  assign stat_misses    = misses_q;
  assign stat_evictions = evictions_q;
`endif

endmodule

// File: tb/tb_second_chance_ctrl.sv
// Scoreboard bench for second_chance_ctrl driving a behavioural 4-entry key array.
module tb_second_chance_ctrl;

  localparam int unsigned KW = 8;
  localparam int unsigned MS = 4;
  localparam int unsigned IW = 2;
  localparam logic [1:0] OP_LK = 2'd0;
  localparam logic [1:0] OP_IN = 2'd1;
  localparam logic [1:0] OP_DL = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, resp_valid, resp_ready;
  logic [1:0]    req_op;
  logic [KW-1:0] req_key, key_write_o, key_read_o;
  logic          resp_hit, resp_evicted, cs_o;
  logic [IW-1:0] resp_index;
  logic [MS-1:0] we_o, del_o, empty_i, fits_read_i, fits_write_i;
`ifdef SECOND_CHANCE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_evictions;
`endif

  second_chance_ctrl #(.KEY_WIDTH(KW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_index(resp_index), .resp_evicted(resp_evicted),
    .key_write_o(key_write_o), .key_read_o(key_read_o), .cs_o(cs_o),
    .we_o(we_o), .del_o(del_o), .empty_i(empty_i),
    .fits_read_i(fits_read_i), .fits_write_i(fits_write_i)
`ifdef SECOND_CHANCE_STATS_EN
    , .stat_clr(1'b0), .stat_hits(stat_hits), .stat_misses(stat_misses),
    .stat_evictions(stat_evictions)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural key array; only arr_clr clears it, the controller reset does not.
  logic          arr_clr;
  logic [KW-1:0] arr_key [MS];
  logic [MS-1:0] arr_vld;

  always_ff @(posedge clk) begin
    if (arr_clr) begin
      arr_vld <= '0;
    end else begin
      for (int i = 0; i < MS; i++) begin
        if (we_o[i]) begin
          arr_key[i] <= key_write_o;
          arr_vld[i] <= 1'b1;
        end else if (del_o[i]) begin
          arr_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MS; i++) begin
      fits_read_i[i]  = arr_vld[i] && (arr_key[i] == key_read_o);
      fits_write_i[i] = arr_vld[i] && (arr_key[i] == key_write_o);
    end
    empty_i = ~arr_vld;
  end

  typedef struct {
    logic          hit;
    logic [IW-1:0] idx;
    logic          ev;
    logic [MS-1:0] we;
    logic [MS-1:0] del;
    int            lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic hit, input logic [IW-1:0] idx, input logic ev,
                              input logic [MS-1:0] we, input logic [MS-1:0] del,
                              input int lat);
    exp_t e;
    e.hit = hit; e.idx = idx; e.ev = ev; e.we = we; e.del = del; e.lat = lat;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, ".req_ready"},  32'(req_ready), 32'd1);
    check_eq({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, ".cs"},         32'(cs_o), 32'd0);
    check_eq({tag, ".we_del"},     32'({we_o, del_o}), 32'd0);
    check_eq({tag, ".keys"},       32'({key_write_o, key_read_o}), 32'd0);
    check_eq({tag, ".resp"},       32'({resp_hit, resp_index, resp_evicted}), 32'd0);
  endtask

  // Push expectation, drive one request, collect array strobes until the response.
  task automatic run_req(input string tag, input logic [1:0] op, input logic [KW-1:0] key,
                         input exp_t e, input int stall);
    int            lat;
    int            we_n, del_n;
    logic [MS-1:0] we_acc, del_acc;
    logic          hit_s, ev_s;
    logic [IW-1:0] idx_s;
    exp_t          x;
    sb_q.push_back(e);
    check_eq({tag, ".ready_before"}, 32'(req_ready), 32'd1);
    req_op = op; req_key = key; req_valid = 1'b1; resp_ready = (stall == 0);
    lat = 0; we_n = 0; del_n = 0; we_acc = '0; del_acc = '0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (we_o != '0)  begin we_acc  |= we_o;  we_n++;  end
      if (del_o != '0) begin del_acc |= del_o; del_n++; end
      if (resp_valid) break;
    end
    x = sb_q.pop_front();
    check_eq({tag, ".resp_seen"}, 32'(resp_valid), 32'd1);
    check_eq({tag, ".latency"},   32'(lat), 32'(x.lat));
    check_eq({tag, ".hit"},       32'(resp_hit), 32'(x.hit));
    check_eq({tag, ".index"},     32'(resp_index), 32'(x.idx));
    check_eq({tag, ".evicted"},   32'(resp_evicted), 32'(x.ev));
    check_eq({tag, ".we"},        32'(we_acc), 32'(x.we));
    check_eq({tag, ".we_cycles"}, 32'(we_n), (x.we != '0) ? 32'd1 : 32'd0);
    check_eq({tag, ".del"},       32'(del_acc), 32'(x.del));
    check_eq({tag, ".del_cycles"}, 32'(del_n), (x.del != '0) ? 32'd1 : 32'd0);
    if (stall > 0) begin
      hit_s = resp_hit; idx_s = resp_index; ev_s = resp_evicted;
      // Offer a competing request while the response is held.
      req_op = OP_IN; req_key = 8'h77; req_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check_eq({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
        check_eq({tag, ".stall_resp"}, 32'({resp_hit, resp_index, resp_evicted}),
                 32'({hit_s, idx_s, ev_s}));
        check_eq({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, ".stall_cs"}, 32'({cs_o, we_o}), 32'd0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    check_eq({tag, ".resp_drop"}, 32'(resp_valid), 32'd0);
    resp_ready = 1'b0;
  endtask

  initial begin
    int  n;
    logic seen_cs, in_sweep;
    reset = 1'b1; arr_clr = 1'b1;
    req_valid = 1'b0; req_op = OP_LK; req_key = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    reset = 1'b0; arr_clr = 1'b0;
    @(negedge clk);

    run_req("ins_a", OP_IN, 8'h0A, mk(1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 3), 0);
    run_req("ins_b", OP_IN, 8'h0B, mk(1'b0, 2'd1, 1'b0, 4'b0010, 4'b0000, 3), 0);
    run_req("ins_c", OP_IN, 8'h0C, mk(1'b0, 2'd2, 1'b0, 4'b0100, 4'b0000, 3), 0);
    run_req("ins_d", OP_IN, 8'h0D, mk(1'b0, 2'd3, 1'b0, 4'b1000, 4'b0000, 3), 0);
    run_req("lk_b",  OP_LK, 8'h0B, mk(1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000, 3), 0);
    // All refs set: four clears, a fifth sweep picks entry 0, then ACT and RESP.
    run_req("ins_e", OP_IN, 8'h0E, mk(1'b0, 2'd0, 1'b1, 4'b0001, 4'b0000, 9), 0);
    run_req("lk_a",  OP_LK, 8'h0A, mk(1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 3), 0);
    run_req("del_c", OP_DL, 8'h0C, mk(1'b1, 2'd2, 1'b0, 4'b0000, 4'b0100, 3), 0);
    run_req("ins_f", OP_IN, 8'h0F, mk(1'b0, 2'd2, 1'b0, 4'b0100, 4'b0000, 3), 0);
    // Hand sits at 1 with ref[1] cleared by the earlier sweep.
    run_req("ins_10", OP_IN, 8'h10, mk(1'b0, 2'd1, 1'b1, 4'b0010, 4'b0000, 5), 0);
    run_req("ins_f2", OP_IN, 8'h0F, mk(1'b1, 2'd2, 1'b0, 4'b0000, 4'b0000, 3), 0);
    run_req("rsv_op", 2'd3, 8'h0E, mk(1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 3), 0);
    run_req("stall", OP_LK, 8'h0D, mk(1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000, 3), 5);

    // Full array, every ref set: abort an insert while it sweeps.
    req_op = OP_IN; req_key = 8'h20; req_valid = 1'b1;
    seen_cs = 1'b0; in_sweep = 1'b0; n = 0;
    while (n < 20 && !in_sweep) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) req_valid = 1'b0;
      if (cs_o) seen_cs = 1'b1;
      else if (seen_cs) in_sweep = 1'b1;
    end
    check_eq("sweep_reached", 32'(in_sweep), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_sweep");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Cleared refs and hand: victim is entry 0 after a single sweep cycle.
    run_req("ins_21", OP_IN, 8'h21, mk(1'b0, 2'd0, 1'b1, 4'b0001, 4'b0000, 5), 0);
    run_req("lk_21",  OP_LK, 8'h21, mk(1'b1, 2'd0, 1'b0, 4'b0000, 4'b0000, 3), 0);
    run_req("lk_20",  OP_LK, 8'h20, mk(1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 3), 0);
    run_req("del_miss", OP_DL, 8'h0C, mk(1'b0, 2'd0, 1'b0, 4'b0000, 4'b0000, 3), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
